io_bridge: RTL and testbench
============================

# io_bridge

Memory-mapped I/O bridge between the RV32 core's load/store bus and the 30-bit external pin pair (a 1-bit valid strobe plus 30-bit data in each direction). It sits directly downstream of the core on the data-bus side. Inbound, it synchronises and captures words arriving from the pins. Outbound, it buffers core stores in a small FIFO and drains them to the pins under a valid/ready handshake.

## Interface
Parameters:
- DW, 30, external data width
- DEPTH, 4, output FIFO depth (power of two)

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- bus_addr  in  4  byte offset: 0x0 STATUS, 0x4 IN_DATA, 0x8 OUT_DATA
- bus_wdata  in  32  store data
- bus_we  in  1  store strobe, one cycle per access
- bus_re  in  1  load strobe, one cycle per access
- bus_rdata  out  32  load data, registered
- ext_in_valid  in  1  asynchronous inbound strobe
- ext_in_data  in  DW  inbound word; stable while ext_in_valid is high
- ext_out_valid  out  1  FIFO head valid
- ext_out_data  out  DW  FIFO head word
- ext_out_ready  in  1  external sink accepts the head

## Operation
- Reset (rst low, asynchronous) clears:
  - bus_rdata, ext_out_valid, ext_out_data to 0
  - FIFO pointers and count to 0
  - both synchroniser flops, the edge-history flop, in_latch, in_pending, overflow, overrun to 0
- Inbound path:
  - ext_in_valid passes through a 2-flop synchroniser, then a history flop.
  - A rising edge is sync2 & ~hist.
  - On an edge: in_latch <= ext_in_data, and in_pending <= 1.
  - If in_pending is already 1 at the edge, the new word overwrites in_latch and overrun is set (sticky).
- STATUS read (0x0):
  - bit0 in_pending, bit1 full, bit2 empty, bit3 overflow, bits[6:4] count, bit7 overrun, others 0.
- STATUS write (0x0):
  - writing 1 to bit3 or bit7 clears that sticky bit.
  - The clear wins over a same-cycle set.
- IN_DATA read (0x4):
  - returns {2'b0, in_latch} and clears in_pending.
  - If a capture edge occurs in the same cycle, the read returns the old latch, in_pending stays 1, and the new word is latched.
- OUT_DATA write (0x8):
  - pushes bus_wdata[DW-1:0].
  - A push while full is dropped, sets overflow, and leaves the FIFO unchanged.
- Outbound drain:
  - ext_out_valid = !empty.
  - ext_out_data = head entry, driven as 0 when empty.
  - Pop when ext_out_valid & ext_out_ready.
- Simultaneous push and pop:
  - both take effect and the count is unchanged.
  - When full, the push is accepted because a pop frees a slot in the same cycle; overflow is not set.
- Pointer and count arithmetic:
  - pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, 0..DEPTH.
- Access rules:
  - Loads from 0x8 or unmapped offsets return 0.
  - Stores to 0x4 or unmapped offsets are ignored.
  - bus_we and bus_re high together: the store is performed; the load returns pre-store state.

## Timing
- Load latency is 1 cycle: bus_rdata is valid on the edge after bus_re and holds until the next load. Side effects (pending clear) happen on the bus_re edge.
- Inbound latency:
  - ext_in_valid rising before edge k is captured at edge k+2.
  - in_pending is visible in STATUS via a load issued in cycle k+3.
  - ext_in_valid must stay high for at least 3 clk periods, and low for at least 3 between words.
- Outbound latency: no bypass. A push at edge k gives ext_out_valid high after edge k, so the head is visible one cycle after the store.
- Reset release with ext_in_valid already high: registers as an edge and captures about 3 cycles later.
- Reset mid-transfer: the FIFO contents are discarded and ext_out_valid drops immediately (asynchronous).

## Test plan
- Reset: hold rst=0 with ext_out_ready=1, then release.
  - bus_rdata=0, ext_out_valid=0, and a STATUS load returns 0x04 (empty only).
- Inbound capture: set ext_in_data=30'h2AAAAAAA, pulse ext_in_valid high for 4 cycles.
  - STATUS bit0=1 by cycle 4.
  - An IN_DATA load returns 32'h2AAAAAAA; a following STATUS load has bit0=0.
- Overrun: deliver two words, 0x1 then 0x2, without reading.
  - IN_DATA returns 0x2 and STATUS bit7=1.
  - Writing 0x80 to STATUS clears bit7.
- FIFO fill and overflow: with ext_out_ready=0, store 1,2,3,4,5 to OUT_DATA.
  - STATUS shows count=4, full=1, overflow=1.
  - Raising ready drains 1,2,3,4 on consecutive cycles, then ext_out_valid=0.
- Full plus simultaneous push and pop: fill with 1..4, then in one cycle hold ready=1 and store 9.
  - Count stays 4, overflow stays 0, and the drain order is 2,3,4,9.
- Reset mid-drain: with 3 entries queued, assert rst for 1 cycle.
  - ext_out_valid falls without waiting for a clock edge; after release the count is 0.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped bridge between the core load/store bus and the
// external valid/data pin pairs. Inbound words are synchronised and latched.
// Outbound stores are queued in a small FIFO that drains under valid/ready.
module io_bridge #(
    parameter int DW    = 30,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    bus_addr,
    input  logic [31:0]   bus_wdata,
    input  logic          bus_we,
    input  logic          bus_re,
    output logic [31:0]   bus_rdata,
    input  logic          ext_in_valid,
    input  logic [DW-1:0] ext_in_data,
    output logic          ext_out_valid,
    output logic [DW-1:0] ext_out_data,
    input  logic          ext_out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_IN     = 4'h4;
    localparam logic [3:0] ADDR_OUT    = 4'h8;

    // Inbound state
    logic          sync1;
    logic          sync2;
    logic          hist;
    logic          capture;
    logic [DW-1:0] in_latch;
    logic          in_pending;
    logic          overrun;

    // Outbound state
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    // Bus decode
    logic          sel_status;
    logic          sel_in;
    logic          sel_out;
    logic          clr_overflow;
    logic          clr_overrun;
    logic          in_read;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [31:0]   read_data;
    logic [31:0]   status_word;

    // Upper store-data bits have no destination when DW < 32.
    logic          unused_wdata;
    assign unused_wdata = ^bus_wdata[31:DW];

    assign sel_status   = (bus_addr == ADDR_STATUS);
    assign sel_in       = (bus_addr == ADDR_IN);
    assign sel_out      = (bus_addr == ADDR_OUT);
    assign clr_overflow = bus_we & sel_status & bus_wdata[3];
    assign clr_overrun  = bus_we & sel_status & bus_wdata[7];
    assign in_read      = bus_re & sel_in;
    assign push_req     = bus_we & sel_out;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = !empty && ext_out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push    = push_req && (!full || pop);
    assign capture = sync2 & ~hist;

    assign ext_out_valid = !empty;
    assign ext_out_data  = empty ? '0 : mem[rd_ptr];

    // Two-flop synchroniser for the asynchronous strobe plus edge history.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ext_in_valid;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Inbound capture: a new edge wins over a same-cycle IN_DATA read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_latch   <= '0;
            in_pending <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (capture) begin
                in_latch   <= ext_in_data;
                in_pending <= 1'b1;
            end else if (in_read) begin
                in_pending <= 1'b0;
            end
            if (clr_overrun) begin
                overrun <= 1'b0;
            end else if (capture && in_pending) begin
                overrun <= 1'b1;
            end
        end
    end

    // Sticky overflow: set by a dropped push, software clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end else if (push_req && !push) begin
            overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: the data array has no reset; entries are only visible once the
    // count covers them, and output data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_wdata[DW-1:0];
        end
    end

    // Load mux built from pre-edge state, so a same-cycle store is not seen.
    // NOTE: read_data is assigned a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        status_word      = '0;
        status_word[0]   = in_pending;
        status_word[1]   = full;
        status_word[2]   = empty;
        status_word[3]   = overflow;
        status_word[6:4] = 3'(count);
        status_word[7]   = overrun;
        read_data        = '0;
        if (sel_status) begin
            read_data = status_word;
        end else if (sel_in) begin
            read_data = 32'(in_latch);
        end
    end

    // Registered load data, held between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            bus_rdata <= read_data;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed scenarios followed by randomized traffic, all
// compared against a queue-based behavioural model of the bridge.
module tb_io_bridge;

    localparam int DW    = 30;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_we;
    logic          bus_re;
    logic [31:0]   bus_rdata;
    logic          ext_in_valid;
    logic [DW-1:0] ext_in_data;
    logic          ext_out_valid;
    logic [DW-1:0] ext_out_data;
    logic          ext_out_ready;

    io_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_rdata     (bus_rdata),
        .ext_in_valid  (ext_in_valid),
        .ext_in_data   (ext_in_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model
    logic [DW-1:0] m_q[$];
    bit            m_pend;
    bit            m_ovf;
    bit            m_ovr;
    logic [DW-1:0] m_latch;
    logic [31:0]   m_rdata;
    bit            v_prev;      // strobe value at the previous edge
    bit            rose_1;      // strobe rose one edge ago
    bit            rose_2;      // strobe rose two edges ago
    bit            rdy;

    task automatic model_reset();
        m_q.delete();
        m_pend  = 0;
        m_ovf   = 0;
        m_ovr   = 0;
        m_latch = '0;
        m_rdata = '0;
        v_prev  = 0;
        rose_1  = 0;
        rose_2  = 0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = m_pend;
        s[1]   = (m_q.size() == DEPTH);
        s[2]   = (m_q.size() == 0);
        s[3]   = m_ovf;
        s[6:4] = 3'(m_q.size());
        s[7]   = m_ovr;
        return s;
    endfunction

    // One bus cycle: drive, advance the model across the edge, then compare.
    task automatic step(input bit we, input bit re, input logic [3:0] addr, input logic [31:0] wdata);
        bit full;
        bit pop;
        bit push_req;
        bit cap;
        bit wr_status;
        bus_we        = we;
        bus_re        = re;
        bus_addr      = addr;
        bus_wdata     = wdata;
        ext_out_ready = rdy;

        full      = (m_q.size() == DEPTH);
        pop       = (m_q.size() != 0) && rdy;
        push_req  = we && (addr == 4'h8);
        wr_status = we && (addr == 4'h0);
        // A strobe rising before edge k is captured at edge k+2.
        cap       = rose_2;

        if (re) begin
            if (addr == 4'h0)      m_rdata = m_status();
            else if (addr == 4'h4) m_rdata = 32'(m_latch);
            else                   m_rdata = '0;
        end
        if (wr_status && wdata[3])           m_ovf = 0;
        else if (push_req && full && !pop)   m_ovf = 1;
        if (wr_status && wdata[7])           m_ovr = 0;
        else if (cap && m_pend)              m_ovr = 1;
        if (cap) begin
            m_pend  = 1;
            m_latch = ext_in_data;
        end else if (re && addr == 4'h4) begin
            m_pend = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push_req && (!full || pop)) m_q.push_back(wdata[DW-1:0]);

        rose_2 = rose_1;
        rose_1 = ext_in_valid && !v_prev;
        v_prev = ext_in_valid;

        @(posedge clk);
        #1;
        bus_we = 1'b0;
        bus_re = 1'b0;
        check("rdata", bus_rdata, m_rdata);
        check("out_valid", 32'(ext_out_valid), 32'(m_q.size() != 0));
        check("out_data", 32'(ext_out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 32'h0);
    endtask

    task automatic ld(input logic [3:0] addr);
        step(0, 1, addr, 32'h0);
    endtask

    task automatic st(input logic [3:0] addr, input logic [31:0] data);
        step(1, 0, addr, data);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        ext_in_data  = d;
        ext_in_valid = 1'b1;
        idle(3);
        ext_in_valid = 1'b0;
        idle(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        logic [3:0] addr;

        // Reset
        rst           = 1'b0;
        rdy           = 1'b1;
        ext_out_ready = 1'b1;
        bus_we        = 1'b0;
        bus_re        = 1'b0;
        bus_addr      = '0;
        bus_wdata     = '0;
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_valid", 32'(ext_out_valid), 32'h0);
        rst = 1'b1;
        ld(4'h0);
        check("reset_status", bus_rdata, 32'h4);

        // Inbound capture
        ext_in_data  = 30'h2AAAAAAA;
        ext_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) ld(4'h0);
        check("in_pending_set", 32'(bus_rdata[0]), 32'h1);
        ext_in_valid = 1'b0;
        ld(4'h4);
        check("in_data", bus_rdata, 32'h2AAAAAAA);
        ld(4'h0);
        check("in_pending_clr", 32'(bus_rdata[0]), 32'h0);
        idle(3);

        // Overrun
        send_word(30'h1);
        send_word(30'h2);
        ld(4'h4);
        check("overrun_data", bus_rdata, 32'h2);
        ld(4'h0);
        check("overrun_set", 32'(bus_rdata[7]), 32'h1);
        st(4'h0, 32'h80);
        ld(4'h0);
        check("overrun_clr", 32'(bus_rdata[7]), 32'h0);

        // FIFO fill and overflow
        rdy = 1'b0;
        for (int v = 1; v <= 5; v++) st(4'h8, 32'(v));
        ld(4'h0);
        check("fill_status", bus_rdata, 32'h4A);
        rdy = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check("drain_order", 32'(ext_out_data), 32'(v));
            idle(1);
        end
        check("drain_empty", 32'(ext_out_valid), 32'h0);
        st(4'h0, 32'h08);

        // Full plus simultaneous push and pop
        rdy = 1'b0;
        for (int v = 1; v <= 4; v++) st(4'h8, 32'(v));
        rdy = 1'b1;
        st(4'h8, 32'h9);
        rdy = 1'b0;
        ld(4'h0);
        check("pushpop_status", bus_rdata, 32'h42);
        rdy = 1'b1;
        check("pushpop_d0", 32'(ext_out_data), 32'h2);
        idle(1);
        check("pushpop_d1", 32'(ext_out_data), 32'h3);
        idle(1);
        check("pushpop_d2", 32'(ext_out_data), 32'h4);
        idle(1);
        check("pushpop_d3", 32'(ext_out_data), 32'h9);
        idle(1);
        check("pushpop_empty", 32'(ext_out_valid), 32'h0);

        // Reset mid-drain
        rdy = 1'b0;
        for (int v = 1; v <= 3; v++) st(4'h8, 32'(v));
        check("pre_reset_valid", 32'(ext_out_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_valid", 32'(ext_out_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ld(4'h0);
        check("post_reset_status", bus_rdata, 32'h4);

        // Randomized traffic
        hold = 3;
        for (int n = 0; n < 500; n++) begin
            if (hold == 0) begin
                ext_in_valid = !ext_in_valid;
                if (ext_in_valid) ext_in_data = DW'($urandom);
                hold = $urandom_range(3, 6);
            end
            hold--;
            case ($urandom_range(0, 3))
                0:       addr = 4'h0;
                1:       addr = 4'h4;
                2:       addr = 4'h8;
                default: addr = 4'($urandom);
            endcase
            rdy = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), addr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
